// File: rtl/mac_pkg.sv
// Shared definitions for the output-stationary MAC PE: FIFO sizing and the
// saturating/wrapping accumulate helper.
package mac_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    // Internal arithmetic width for sat_add; accumulators must be narrower.
    localparam int unsigned ACC_MAX = 64;
    localparam int unsigned EXT_W   = ACC_MAX + 2;

    localparam logic signed [EXT_W-1:0] EXT_ONE = {{(EXT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic               ovf;
        logic [ACC_MAX-1:0] sum;
    } add_res_t;

    // Adds two operands already extended to ACC_MAX and checks the result
    // against the acc_w-bit range; clamps when saturate is set, else wraps.
    function automatic add_res_t sat_add(
        input logic [ACC_MAX-1:0] a,
        input logic [ACC_MAX-1:0] b,
        input logic               signed_mode,
        input logic               saturate,
        input int unsigned        acc_w
    );
        logic signed [EXT_W-1:0] sa;
        logic signed [EXT_W-1:0] sb;
        logic signed [EXT_W-1:0] s;
        logic signed [EXT_W-1:0] vmax;
        logic signed [EXT_W-1:0] vmin;
        add_res_t                r;
        sa   = signed_mode ? {{2{a[ACC_MAX-1]}}, a} : {2'b00, a};
        sb   = signed_mode ? {{2{b[ACC_MAX-1]}}, b} : {2'b00, b};
        s    = sa + sb;
        vmax = signed_mode ? ((EXT_ONE <<< (acc_w - 1)) - EXT_ONE)
                           : ((EXT_ONE <<< acc_w) - EXT_ONE);
        vmin = signed_mode ? -(EXT_ONE <<< (acc_w - 1)) : '0;
        r.ovf = (s > vmax) || (s < vmin);
        r.sum = ACC_MAX'(s);
        if (saturate && (s > vmax)) begin
            r.sum = ACC_MAX'(vmax);
        end else if (saturate && (s < vmin)) begin
            r.sum = ACC_MAX'(vmin);
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_result_fifo.sv
// Small valid/ready result FIFO; push and pop may coincide, pop when empty is ignored.
module pe_result_fifo
    import mac_pkg::*;
#(
    parameter type entry_t = logic
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_push,
    input  entry_t                i_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output entry_t                o_data,
    output logic [FIFO_CNT_W-1:0] o_count
);

    entry_t                mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_CNT_W-1:0] count;
    logic                  do_push;
    logic                  do_pop;

    // Qualify push/pop against occupancy.
    always_comb begin
        do_pop  = i_pop && (count != '0);
        do_push = i_push && ((count < FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr <= (wr_ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + FIFO_PTR_W'(1);
            end
            count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        end
    end

    assign o_valid = (count != '0);
    assign o_data  = mem[rd_ptr];
    assign o_count = count;

endmodule

// File: rtl/mac_pe_os.sv
// Output-stationary systolic MAC PE: accumulates run-time-length dot products,
// forwards operands east/south, and queues results in a 2-entry FIFO.
module mac_pe_os
    import mac_pkg::*;
#(
    parameter int unsigned BW     = 8,
    parameter int unsigned ACC_W  = 32,  // >= 2*BW and < ACC_MAX
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned SIGNED = 1,
    parameter int unsigned SAT    = 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [BW-1:0]    i_activation,
    input  logic [BW-1:0]    i_weight,
    output logic             o_fwd_valid,
    output logic [BW-1:0]    o_activation,
    output logic [BW-1:0]    o_weight,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [ACC_W-1:0] o_result,
    output logic             o_ovf
);

    localparam logic SGN  = (SIGNED != 0);
    localparam logic SATL = (SAT != 0);

    typedef struct packed {
        logic             ovf;
        logic [ACC_W-1:0] res;
    } fifo_entry_t;

    logic                  accept;
    logic                  first_beat;
    logic                  last_beat;
    logic [LEN_W-1:0]      cnt;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      eff_len;
    logic                  s1_valid;
    logic                  s1_first;
    logic                  s1_last;
    logic [BW-1:0]         s1_a;
    logic [BW-1:0]         s1_w;
    logic [2*BW-1:0]       ext_a;
    logic [2*BW-1:0]       ext_w;
    logic [2*BW-1:0]       prod;
    logic [ACC_MAX-1:0]    prod_x;
    logic [ACC_MAX-1:0]    acc_x;
    add_res_t              sum;
    logic [ACC_W-1:0]      acc;
    logic                  acc_ovf;
    logic                  s2_last;
    logic                  push;
    fifo_entry_t           push_data;
    fifo_entry_t           head;
    logic [FIFO_CNT_W-1:0] fifo_count;

    assign accept = i_valid && o_ready;

    // Beat position within the vector; a zero length counts as one beat.
    always_comb begin
        first_beat = (cnt == '0);
        eff_len    = len_q;
        if (first_beat) begin
            eff_len = (i_len == '0) ? LEN_W'(1) : i_len;
        end
        last_beat = (cnt == eff_len - LEN_W'(1));
    end

    // Beat counter and latched vector length.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (i_clear) begin
            cnt <= '0;
        end else if (accept) begin
            if (first_beat) begin
                len_q <= eff_len;
            end
            cnt <= last_beat ? '0 : cnt + LEN_W'(1);
        end
    end

    // Operand forwarding to neighbours, unaffected by i_clear.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_fwd_valid  <= 1'b0;
            o_activation <= '0;
            o_weight     <= '0;
        end else begin
            o_fwd_valid <= accept;
            if (accept) begin
                o_activation <= i_activation;
                o_weight     <= i_weight;
            end
        end
    end

    // S1: capture operands and vector-position flags; a clear drops the beat.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_w     <= '0;
        end else begin
            s1_valid <= accept && !i_clear;
            if (accept) begin
                s1_first <= first_beat;
                s1_last  <= last_beat;
                s1_a     <= i_activation;
                s1_w     <= i_weight;
            end
        end
    end

    // S2 datapath: full-width product extended into the accumulator add.
    always_comb begin
        ext_a  = SGN ? {{BW{s1_a[BW-1]}}, s1_a} : {{BW{1'b0}}, s1_a};
        ext_w  = SGN ? {{BW{s1_w[BW-1]}}, s1_w} : {{BW{1'b0}}, s1_w};
        prod   = ext_a * ext_w;
        prod_x = {{(ACC_MAX - 2*BW){SGN & prod[2*BW-1]}}, prod};
        acc_x  = s1_first ? '0 : {{(ACC_MAX - ACC_W){SGN & acc[ACC_W-1]}}, acc};
        sum    = sat_add(acc_x, prod_x, SGN, SATL, ACC_W);
    end

    // S2: accumulator, sticky overflow and result-ready flag.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            s2_last <= 1'b0;
        end else if (i_clear) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s2_last <= s1_valid && s1_last;
            if (s1_valid) begin
                acc     <= ACC_W'(sum.sum);
                acc_ovf <= (acc_ovf && !s1_first) || sum.ovf;
            end
        end
    end

    // A finished vector enters the FIFO unless a clear kills it.
    always_comb begin
        push          = s2_last && !i_clear;
        push_data.ovf = acc_ovf;
        push_data.res = acc;
    end

    pe_result_fifo #(
        .entry_t (fifo_entry_t)
    ) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_push    (push),
        .i_data    (push_data),
        .i_pop     (i_out_ready),
        .o_valid   (o_out_valid),
        .o_data    (head),
        .o_count   (fifo_count)
    );

    // Reserve FIFO space for every finished vector still in the pipeline.
    assign o_ready = (3'(fifo_count) + 3'(s1_valid && s1_last) + 3'(s2_last)) < 3'(FIFO_DEPTH);

    assign o_result = head.res;
    assign o_ovf    = head.ovf;

endmodule

// File: tb/tb_mac_pe_os.sv
// Self-checking bench for mac_pe_os: four parameter variants share one stimulus
// stream and are checked against an arithmetic dot-product reference.
module tb_mac_pe_os;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [7:0] len;
    logic       vld;
    logic [7:0] act;
    logic [7:0] wgt;
    logic       out_ready;

    logic        rdy [4];
    logic        fv  [4];
    logic [7:0]  oa  [4];
    logic [7:0]  ow  [4];
    logic        ov  [4];
    logic        ovf [4];
    logic [31:0] r0;
    logic [31:0] r1;
    logic [15:0] r2;
    logic [15:0] r3;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]       ovf;
        logic [3:0][31:0] res;
    } exp_t;

    exp_t   eq[$];
    longint mv   [4];
    bit     movf [4];
    int     mcnt = 0;
    int     mlen = 1;
    bit     rnd_done;

    always #5 clk = ~clk;

    // 0: signed sat 32b, 1: unsigned sat 32b, 2: signed sat 16b, 3: signed wrap 16b
    mac_pe_os #(.BW(8), .ACC_W(32), .LEN_W(8), .SIGNED(1), .SAT(1)) u_s32 (
        .i_clock(clk), .i_reset_n(rst_n), .i_clear(clr), .i_len(len), .i_valid(vld),
        .o_ready(rdy[0]), .i_activation(act), .i_weight(wgt), .o_fwd_valid(fv[0]),
        .o_activation(oa[0]), .o_weight(ow[0]), .o_out_valid(ov[0]),
        .i_out_ready(out_ready), .o_result(r0), .o_ovf(ovf[0]));
    mac_pe_os #(.BW(8), .ACC_W(32), .LEN_W(8), .SIGNED(0), .SAT(1)) u_u32 (
        .i_clock(clk), .i_reset_n(rst_n), .i_clear(clr), .i_len(len), .i_valid(vld),
        .o_ready(rdy[1]), .i_activation(act), .i_weight(wgt), .o_fwd_valid(fv[1]),
        .o_activation(oa[1]), .o_weight(ow[1]), .o_out_valid(ov[1]),
        .i_out_ready(out_ready), .o_result(r1), .o_ovf(ovf[1]));
    mac_pe_os #(.BW(8), .ACC_W(16), .LEN_W(8), .SIGNED(1), .SAT(1)) u_s16sat (
        .i_clock(clk), .i_reset_n(rst_n), .i_clear(clr), .i_len(len), .i_valid(vld),
        .o_ready(rdy[2]), .i_activation(act), .i_weight(wgt), .o_fwd_valid(fv[2]),
        .o_activation(oa[2]), .o_weight(ow[2]), .o_out_valid(ov[2]),
        .i_out_ready(out_ready), .o_result(r2), .o_ovf(ovf[2]));
    mac_pe_os #(.BW(8), .ACC_W(16), .LEN_W(8), .SIGNED(1), .SAT(0)) u_s16wrap (
        .i_clock(clk), .i_reset_n(rst_n), .i_clear(clr), .i_len(len), .i_valid(vld),
        .o_ready(rdy[3]), .i_activation(act), .i_weight(wgt), .o_fwd_valid(fv[3]),
        .o_activation(oa[3]), .o_weight(ow[3]), .o_out_valid(ov[3]),
        .i_out_ready(out_ready), .o_result(r3), .o_ovf(ovf[3]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accumulate step of variant k with its overflow policy.
    function automatic void acc_step(input int k, input longint p);
        int     wd   = (k >= 2) ? 16 : 32;
        bit     sg   = (k != 1);
        longint span = longint'(1) <<< wd;
        longint mx   = sg ? (span / 2 - 1) : (span - 1);
        longint mn   = sg ? -(span / 2) : 0;
        longint s    = mv[k] + p;
        if (s > mx || s < mn) begin
            movf[k] = 1'b1;
            if (k == 3) begin
                s = s % span;
                if (s < 0) s += span;
                if (s > mx) s -= span;
            end else begin
                s = (s > mx) ? mx : mn;
            end
        end
        mv[k] = s;
    endfunction

    // Reference for one accepted beat; completed vectors join the expected queue.
    function automatic void model_accept(input logic [7:0] a, input logic [7:0] w,
                                         input logic [7:0] l, input bit c);
        longint ps;
        longint pu;
        exp_t   e;
        if (c) begin
            mcnt = 0;
            return;
        end
        if (mcnt == 0) begin
            mlen = (l == 8'd0) ? 1 : int'(l);
            for (int k = 0; k < 4; k++) begin
                mv[k]   = 0;
                movf[k] = 1'b0;
            end
        end
        ps = longint'($signed(a)) * longint'($signed(w));
        pu = longint'(a) * longint'(w);
        for (int k = 0; k < 4; k++) acc_step(k, (k == 1) ? pu : ps);
        mcnt++;
        if (mcnt == mlen) begin
            for (int k = 0; k < 4; k++) begin
                e.res[k] = 32'(mv[k]);
                e.ovf[k] = movf[k];
            end
            eq.push_back(e);
            mcnt = 0;
        end
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for acceptance, then check forwarding.
    task automatic beat(input logic [7:0] a, input logic [7:0] w,
                        input logic [7:0] l, input bit c);
        int t = 0;
        act = a; wgt = w; len = l; clr = c; vld = 1'b1;
        @(negedge clk);
        while (rdy[0] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("rdy_wait", 64'(rdy[0]), 64'd1);
        if (rdy[0] === 1'b1) begin
            @(posedge clk);
            model_accept(a, w, l, c);
            #1;
            for (int k = 0; k < 4; k++) begin
                chk("fwd_valid", 64'(fv[k]), 64'd1);
                chk("fwd_act", 64'(oa[k]), 64'(a));
                chk("fwd_wgt", 64'(ow[k]), 64'(w));
            end
        end
        vld = 1'b0;
        clr = 1'b0;
    endtask

    // Compare every popped result against the reference queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ov[0] === 1'b1 && out_ready === 1'b1) begin
            chk("pop_expected", 64'(eq.size() != 0), 64'd1);
            if (eq.size() != 0) begin
                exp_t e;
                e = eq.pop_front();
                chk("res_s32", 64'(r0), 64'(e.res[0]));
                chk("res_u32", 64'(r1), 64'(e.res[1]));
                chk("res_s16sat", 64'(r2), 64'(e.res[2][15:0]));
                chk("res_s16wrap", 64'(r3), 64'(e.res[3][15:0]));
                for (int k = 0; k < 4; k++) begin
                    chk("ovf", 64'(ovf[k]), 64'(e.ovf[k]));
                    chk("out_valid", 64'(ov[k]), 64'd1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; len = 8'd0; vld = 1'b0;
        act = 8'd0; wgt = 8'd0; out_ready = 1'b1;

        // Reset state
        #12;
        for (int k = 0; k < 4; k++) begin
            chk("rst_out_valid", 64'(ov[k]), 64'd0);
            chk("rst_fwd_valid", 64'(fv[k]), 64'd0);
            chk("rst_act", 64'(oa[k]), 64'd0);
            chk("rst_wgt", 64'(ow[k]), 64'd0);
            chk("rst_ovf", 64'(ovf[k]), 64'd0);
        end
        chk("rst_res_s32", 64'(r0), 64'd0);
        chk("rst_res_s16", 64'(r2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(1);
        chk("rdy_after_rst", 64'(rdy[0]), 64'd1);

        // len=4 small positive vector, latency and forwarding
        beat(8'd1, 8'd2, 8'd4, 1'b0);
        beat(8'd3, 8'd4, 8'd4, 1'b0);
        beat(8'd5, 8'd6, 8'd4, 1'b0);
        beat(8'd7, 8'd8, 8'd4, 1'b0);
        chk("lat_e0", 64'(ov[0]), 64'd0);
        wait_cycles(1);
        chk("lat_e1", 64'(ov[0]), 64'd0);
        chk("fwd_idle", 64'(fv[0]), 64'd0);
        wait_cycles(1);
        chk("lat_e2", 64'(ov[0]), 64'd1);
        chk("dot100_s32", 64'(r0), 64'd100);
        chk("dot100_u32", 64'(r1), 64'd100);
        chk("dot100_ovf", 64'(ovf[0]), 64'd0);
        wait_cycles(2);

        // Signed extremes
        beat(8'h80, 8'h80, 8'd2, 1'b0);
        beat(8'h7F, 8'hFF, 8'd2, 1'b0);
        wait_cycles(2);
        chk("sgn_s32", 64'(r0), 64'd16257);
        chk("sgn_s16", 64'(r2), 64'd16257);
        chk("sgn_u32", 64'(r1), 64'd48769);
        wait_cycles(1);
        beat(8'hFD, 8'd5, 8'd0, 1'b0);
        wait_cycles(2);
        chk("len0_s32", 64'(r0), 64'hFFFF_FFF1);
        chk("len0_s16", 64'(r2), 64'hFFF1);
        chk("len0_u32", 64'(r1), 64'd1265);
        wait_cycles(1);

        // 16-bit overflow: saturate vs wrap
        for (int i = 0; i < 3; i++) beat(8'h7F, 8'h7F, 8'd3, 1'b0);
        wait_cycles(2);
        chk("ovf_sat_res", 64'(r2), 64'd32767);
        chk("ovf_sat_flag", 64'(ovf[2]), 64'd1);
        chk("ovf_wrap_res", 64'(r3), 64'd48387);
        chk("ovf_wrap_flag", 64'(ovf[3]), 64'd1);
        chk("ovf_s32_res", 64'(r0), 64'd48387);
        chk("ovf_s32_flag", 64'(ovf[0]), 64'd0);
        wait_cycles(3);

        // Backpressure: two results fill the FIFO, then drain in order
        out_ready = 1'b0;
        beat(8'd1, 8'd1, 8'd1, 1'b0);
        chk("bp_rdy_after1", 64'(rdy[0]), 64'd1);
        beat(8'd2, 8'd2, 8'd1, 1'b0);
        chk("bp_rdy_after2", 64'(rdy[0]), 64'd0);
        wait_cycles(3);
        chk("bp_rdy_full", 64'(rdy[0]), 64'd0);
        chk("bp_out_valid", 64'(ov[0]), 64'd1);
        chk("bp_head", 64'(r0), 64'd1);
        fork
            beat(8'd3, 8'd3, 8'd1, 1'b0);
            begin
                wait_cycles(2);
                chk("bp_still_full", 64'(rdy[0]), 64'd0);
                out_ready = 1'b1;
                wait_cycles(1);
                chk("bp_rdy_reassert", 64'(rdy[0]), 64'd1);
            end
        join
        wait_cycles(5);
        chk("bp_drained", 64'(eq.size()), 64'd0);

        // i_clear mid-vector keeps the queued result
        out_ready = 1'b0;
        beat(8'd9, 8'd9, 8'd1, 1'b0);
        wait_cycles(2);
        beat(8'd1, 8'd1, 8'd4, 1'b0);
        beat(8'd1, 8'd1, 8'd4, 1'b0);
        beat(8'd1, 8'd1, 8'd4, 1'b1);
        beat(8'd2, 8'd2, 8'd2, 1'b0);
        beat(8'd3, 8'd3, 8'd2, 1'b0);
        wait_cycles(3);
        chk("clr_head_kept", 64'(r0), 64'd81);
        chk("clr_rdy_full", 64'(rdy[0]), 64'd0);
        out_ready = 1'b1;
        wait_cycles(1);
        chk("clr_second", 64'(r0), 64'd13);
        wait_cycles(3);
        chk("clr_only_two", 64'(ov[0]), 64'd0);
        chk("clr_drained", 64'(eq.size()), 64'd0);

        // Randomised vectors with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int v = 0; v < 30; v++) begin
                    int l = $urandom_range(0, 5);
                    int n = (l == 0) ? 1 : l;
                    for (int b = 0; b < n; b++)
                        beat(8'($urandom), 8'($urandom), 8'(l), 1'b0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_cycles(6);
        chk("rnd_drained", 64'(eq.size()), 64'd0);

        // Reset mid-vector with a queued result
        out_ready = 1'b0;
        beat(8'd7, 8'd7, 8'd1, 1'b0);
        beat(8'd5, 8'd5, 8'd3, 1'b0);
        wait_cycles(2);
        chk("mid_queued", 64'(ov[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(ov[0]), 64'd0);
        chk("mid_rst_res", 64'(r0), 64'd0);
        chk("mid_rst_res16", 64'(r3), 64'd0);
        chk("mid_rst_fwd", 64'(oa[0]), 64'd0);
        eq.delete();
        mcnt = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_cycles(3);
        chk("mid_no_spurious", 64'(ov[0]), 64'd0);
        chk("mid_rdy", 64'(rdy[0]), 64'd1);
        out_ready = 1'b1;
        beat(8'd4, 8'd4, 8'd2, 1'b0);
        beat(8'd2, 8'd3, 8'd2, 1'b0);
        wait_cycles(2);
        chk("mid_next_res", 64'(r0), 64'd22);
        wait_cycles(3);
        chk("final_drained", 64'(eq.size()), 64'd0);
        chk("final_idle", 64'(ov[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
